// File: rtl/shared_timer_arbiter_if.sv
// Purpose: bundles the requester-side request/delay bus and the arbiter-side grant/done/busy status.
// Latency: none, wires only.
// Backpressure: level requests held until done (or dropped to cancel).
// Modports: master = requester side (drives req, delay_in); slave = arbiter side (drives grant, done, busy).
// Optional: ARB_ABORT_FLAG_EN adds the aborted status vector.
interface shared_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] delay_in;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
`ifdef ARB_ABORT_FLAG_EN
  logic [NUM_REQ-1:0]       aborted;
`endif

  modport master (
    output req,
    output delay_in,
    input  grant,
    input  done,
`ifdef ARB_ABORT_FLAG_EN
    input  aborted,
`endif
    input  busy
  );

  modport slave (
    input  req,
    input  delay_in,
    output grant,
    output done,
`ifdef ARB_ABORT_FLAG_EN
    output aborted,
`endif
    output busy
  );
endinterface

// File: rtl/shared_timer_arbiter.sv
// Purpose: round-robin shares one down-counter among NUM_REQ requesters; pulses done to the owner after its delay.
// Latency: grant 1 cycle after req; done D+1 cycles after grant (D = delay sampled at grant).
// Backpressure: losers keep req high and wait; dropping req while owning cancels the count.
// Ports: clk, reset (sync, active-high); bus (slave): req, delay_in in; grant, done, busy out (all registered).
// Optional: define ARB_ABORT_FLAG_EN to add bus.aborted, a one-cycle onehot pulse on cancel.
module shared_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
) (
  input logic                  clk,
  input logic                  reset,
  shared_timer_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
`ifdef ARB_ABORT_FLAG_EN
  logic [NUM_REQ-1:0] aborted_q, aborted_d;
`endif

  // Round-robin pick: scan from the farthest offset back to ptr so the
  // closest set bit (starting at ptr) is the last assignment and wins.
  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [CNT_W-1:0]   win_dly;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_dly = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
        win_dly = bus.delay_in[((int'(ptr_q) + i) % NUM_REQ) * CNT_W +: CNT_W];
      end
    end
  end

  logic [PW-1:0] owner_nxt;
  assign owner_nxt = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    busy_d    = busy_q;
`ifdef ARB_ABORT_FLAG_EN
    aborted_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = COUNT;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          cnt_d   = win_dly;
          busy_d  = 1'b1;
        end
      end
      COUNT: begin
        // Cancel is tested first so it beats a same-edge completion.
        if (!bus.req[owner_q]) begin
          state_d   = IDLE;
          ptr_d     = owner_nxt;
          grant_d   = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
`ifdef ARB_ABORT_FLAG_EN
          aborted_d = grant_q;
`endif
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          ptr_d   = owner_nxt;
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef ARB_ABORT_FLAG_EN
      aborted_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef ARB_ABORT_FLAG_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
`ifdef ARB_ABORT_FLAG_EN
  assign bus.aborted = aborted_q;
`endif
endmodule
